// File: rtl/clock_enable_gen_pkg.sv
// Shared constants and helpers for the clock-enable generator register block.
package clock_enable_gen_pkg;

    // Default base of the generator's window in the I/O register space.
    localparam logic [15:0] CLKGEN_BASE = 16'hFF78;

    // CTRL register bit positions.
    localparam int CTRL_RUN_LSB    = 0;
    localparam int CTRL_RESYNC_BIT = 7;

    // Offset of CTRL within the window: it sits right after the DIV byte pairs.
    function automatic logic [15:0] ctrl_offset(input int num_ch);
        return 16'(2 * num_ch);
    endfunction

    // Merge a bus byte into a divider value held zero-extended to 16 bits.
    // Bits above the real divider width are dropped by the caller's truncation,
    // so writes to them are ignored and they read back as 0.
    function automatic logic [15:0] merge_div_byte(
        input logic [15:0] cur,
        input logic        we_lo,
        input logic        we_hi,
        input logic [7:0]  wdata
    );
        logic [15:0] nxt;
        nxt = cur;
        if (we_lo) nxt[7:0]  = wdata;
        if (we_hi) nxt[15:8] = wdata;
        return nxt;
    endfunction

endpackage

// File: rtl/ce_channel.sv
// One divider channel: bus-visible shadow ratio, active ratio, terminal-count
// counter, and registered one-cycle enable plus 50%-duty phase outputs.
module ce_channel
    import clock_enable_gen_pkg::*;
#(
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_lo,
    input  logic                 we_hi,
    input  logic [7:0]           wdata,
    input  logic                 run,
    input  logic                 resync,
    output logic [DIV_WIDTH-1:0] shadow,
    output logic                 ce,
    output logic                 phase
);

    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic [DIV_WIDTH-1:0] active_q, active_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ce_q, ce_d;
    logic                 phase_q, phase_d;

    // Shadow ratio: byte-wise load from the register bus.
    always_comb begin
        shadow_d = DIV_WIDTH'(merge_div_byte(16'(shadow_q), we_lo, we_hi, wdata));
    end

    // Divider: resync beats run-hold, which beats terminal count. The active
    // ratio is only reloaded (from the pre-edge shadow) at resync or terminal
    // count, so a ratio change never shortens or splits a period.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        phase_d  = phase_q;
        ce_d     = 1'b0;
        if (resync) begin
            cnt_d    = '0;
            phase_d  = 1'b0;
            active_d = shadow_q;
        end else if (run) begin
            if (cnt_q == active_q) begin
                cnt_d    = '0;
                ce_d     = 1'b1;
                phase_d  = ~phase_q;
                active_d = shadow_q;
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    // Channel state registers with asynchronous clear to the reset ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= DIV_WIDTH'(RESET_DIV);
            active_q <= DIV_WIDTH'(RESET_DIV);
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            phase_q  <= phase_d;
        end
    end

    assign shadow = shadow_q;
    assign ce     = ce_q;
    assign phase  = phase_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator with an I/O-bus register window:
// address decode, CTRL (RUN bits + self-clearing RESYNC), read mux and the
// tristate data driver, around NUM_CH divider channels.
module clock_enable_gen
    import clock_enable_gen_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          DIV_WIDTH = 8,
    parameter logic [15:0] BASE_ADDR = CLKGEN_BASE,
    parameter int          RESET_DIV = 3
) (
    input  logic              I_CLK,
    input  logic              I_ASYNC_RESET_L,
    input  logic [15:0]       I_IOREG_ADDR,
    inout  wire logic [7:0]   IO_IOREG_DATA,
    input  logic              I_IOREG_WE_L,
    input  logic              I_IOREG_RE_L,
    output logic [NUM_CH-1:0] O_CE,
    output logic [NUM_CH-1:0] O_PHASE
);

    localparam logic [15:0] CTRL_OFS = ctrl_offset(NUM_CH);

    logic [15:0]          offset;
    logic                 hit;
    logic                 wr_en;
    logic                 rd_en;
    logic                 ctrl_wr;
    logic                 resync;
    logic [NUM_CH-1:0]    run_q, run_d;
    logic [DIV_WIDTH-1:0] shadow [NUM_CH];
    logic [7:0]           rd_data;

    assign offset  = I_IOREG_ADDR - BASE_ADDR;
    assign hit     = (I_IOREG_ADDR >= BASE_ADDR) && (offset <= CTRL_OFS);
    assign wr_en   = hit && !I_IOREG_WE_L;
    // A cycle with both strobes low is treated as a write: never drive the bus then.
    assign rd_en   = hit && !I_IOREG_RE_L && I_IOREG_WE_L;
    assign ctrl_wr = wr_en && (offset == CTRL_OFS);
    // RESYNC is not stored; it acts only on the edge of the CTRL write.
    assign resync  = ctrl_wr && IO_IOREG_DATA[CTRL_RESYNC_BIT];

    // RUN bits follow any CTRL write, including one that also resyncs.
    always_comb begin
        run_d = run_q;
        if (ctrl_wr) run_d = IO_IOREG_DATA[CTRL_RUN_LSB +: NUM_CH];
    end

    // RUN register; every channel runs out of reset.
    always_ff @(posedge I_CLK or negedge I_ASYNC_RESET_L) begin
        if (!I_ASYNC_RESET_L) run_q <= '1;
        else                  run_q <= run_d;
    end

    // Read mux: DIV byte pairs followed by CTRL; RESYNC always reads 0.
    always_comb begin
        logic [15:0] sh16;
        sh16    = '0;
        rd_data = '0;
        if (offset == CTRL_OFS) rd_data[CTRL_RUN_LSB +: NUM_CH] = run_q;
        for (int c = 0; c < NUM_CH; c++) begin
            sh16 = 16'(shadow[c]);
            if (offset == 16'(2 * c))     rd_data = sh16[7:0];
            if (offset == 16'(2 * c + 1)) rd_data = sh16[15:8];
        end
    end

    assign IO_IOREG_DATA = rd_en ? rd_data : 8'bz;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ce_channel #(
            .DIV_WIDTH (DIV_WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk    (I_CLK),
            .rst_n  (I_ASYNC_RESET_L),
            .we_lo  (wr_en && (offset == 16'(2 * c))),
            .we_hi  (wr_en && (offset == 16'(2 * c + 1))),
            .wdata  (IO_IOREG_DATA),
            .run    (run_q[c]),
            .resync (resync),
            .shadow (shadow[c]),
            .ce     (O_CE[c]),
            .phase  (O_PHASE[c])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: a default two-channel instance and a
// one-channel, 12-bit instance sharing clock and reset.
module tb_clock_enable_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_addr, b_addr;
    logic        a_we_l, a_re_l, b_we_l, b_re_l;
    logic        a_drv, b_drv;
    logic [7:0]  a_wdata, b_wdata;
    wire  [7:0]  a_bus, b_bus;
    logic [1:0]  a_ce, a_phase;
    logic [0:0]  b_ce, b_phase;

    int total = 0;
    int bad   = 0;

    assign a_bus = a_drv ? a_wdata : 8'bz;
    assign b_bus = b_drv ? b_wdata : 8'bz;

    clock_enable_gen #(
        .NUM_CH    (2),
        .DIV_WIDTH (8),
        .BASE_ADDR (16'hFF78),
        .RESET_DIV (3)
    ) u_dut (
        .I_CLK           (clk),
        .I_ASYNC_RESET_L (rst_n),
        .I_IOREG_ADDR    (a_addr),
        .IO_IOREG_DATA   (a_bus),
        .I_IOREG_WE_L    (a_we_l),
        .I_IOREG_RE_L    (a_re_l),
        .O_CE            (a_ce),
        .O_PHASE         (a_phase)
    );

    clock_enable_gen #(
        .NUM_CH    (1),
        .DIV_WIDTH (12),
        .BASE_ADDR (16'hFF78),
        .RESET_DIV (3)
    ) u_dut12 (
        .I_CLK           (clk),
        .I_ASYNC_RESET_L (rst_n),
        .I_IOREG_ADDR    (b_addr),
        .IO_IOREG_DATA   (b_bus),
        .I_IOREG_WE_L    (b_we_l),
        .I_IOREG_RE_L    (b_re_l),
        .O_CE            (b_ce),
        .O_PHASE         (b_phase)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus write: held across exactly one rising edge.
    task automatic wr(input bit sel, input logic [15:0] addr, input logic [7:0] data);
        if (!sel) begin
            a_addr = addr; a_wdata = data; a_drv = 1'b1; a_we_l = 1'b0;
        end else begin
            b_addr = addr; b_wdata = data; b_drv = 1'b1; b_we_l = 1'b0;
        end
        tick();
        a_we_l = 1'b1; a_drv = 1'b0;
        b_we_l = 1'b1; b_drv = 1'b0;
    endtask

    // Bus read: combinational, takes one time unit, never spans a clock edge.
    task automatic rd_chk(input bit sel, input string tag, input logic [15:0] addr,
                          input logic [7:0] exp);
        if (!sel) begin a_addr = addr; a_re_l = 1'b0; end
        else      begin b_addr = addr; b_re_l = 1'b0; end
        #1;
        chk(tag, sel ? 16'(b_bus) : 16'(a_bus), 16'(exp));
        a_re_l = 1'b1;
        b_re_l = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int n;
        int hits;
        rst_n   = 1'b0;
        a_addr  = '0; b_addr  = '0;
        a_we_l  = 1'b1; a_re_l = 1'b1; b_we_l = 1'b1; b_re_l = 1'b1;
        a_drv   = 1'b0; b_drv  = 1'b0;
        a_wdata = '0; b_wdata  = '0;
        #1;
        chk("rst_ce", 16'(a_ce), 16'h0);
        chk("rst_phase", 16'(a_phase), 16'h0);
        chk("rst_b_phase", 16'(b_phase), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First CE at edge 4, then every 4 edges; phase toggles on each CE.
        for (int e = 1; e <= 3; e++) begin tick(); chk("ce_before_first", 16'(a_ce[0]), 16'h0); end
        tick();
        chk("ce_edge4", 16'(a_ce), 16'h3);
        chk("phase_edge4", 16'(a_phase), 16'h3);
        for (int e = 5; e <= 7; e++) begin tick(); chk("ce_mid_period", 16'(a_ce[0]), 16'h0); end
        tick();
        chk("ce_edge8", 16'(a_ce[0]), 16'h1);
        chk("phase_edge8", 16'(a_phase[0]), 16'h0);
        rd_chk(0, "rd_div0_lo", 16'hFF78, 8'h03);
        rd_chk(0, "rd_div0_hi", 16'hFF79, 8'h00);
        rd_chk(0, "rd_div1_lo", 16'hFF7A, 8'h03);
        rd_chk(0, "rd_div1_hi", 16'hFF7B, 8'h00);
        rd_chk(0, "rd_ctrl_rst", 16'hFF7C, 8'h03);

        // DIV0=0 written at edge 11: period still ends at edge 12, then CE every cycle.
        tick(); tick();
        wr(0, 16'hFF78, 8'h00);
        chk("div0_period_completes", 16'(a_ce[0]), 16'h0);
        tick();
        chk("div0_tc_edge12", 16'(a_ce), 16'h3);
        chk("phase_edge12", 16'(a_phase[0]), 16'h1);
        tick();
        chk("div0_every_cycle_13", 16'(a_ce), 16'h1);
        chk("phase_toggle_13", 16'(a_phase[0]), 16'h0);
        tick();
        chk("div0_every_cycle_14", 16'(a_ce[0]), 16'h1);
        chk("phase_toggle_14", 16'(a_phase[0]), 16'h1);

        // CTRL=0x01 at edge 15 freezes channel 1 with its phase held high.
        wr(0, 16'hFF7C, 8'h01);
        chk("ch0_runs_15", 16'(a_ce[0]), 16'h1);
        chk("ch0_phase_15", 16'(a_phase[0]), 16'h0);
        for (int e = 16; e <= 19; e++) begin
            tick();
            chk("ch1_frozen_ce", 16'(a_ce[1]), 16'h0);
            chk("ch1_frozen_phase", 16'(a_phase[1]), 16'h1);
        end
        rd_chk(0, "rd_ctrl_01", 16'hFF7C, 8'h01);

        // Restore DIV0=3, then CTRL=0x83 at edge 21: resync and both run again.
        wr(0, 16'hFF78, 8'h03);
        wr(0, 16'hFF7C, 8'h83);
        chk("resync_ce", 16'(a_ce), 16'h0);
        chk("resync_phase", 16'(a_phase), 16'h0);
        for (int e = 22; e <= 24; e++) begin tick(); chk("resync_wait", 16'(a_ce), 16'h0); end
        tick();
        chk("resync_first_ce", 16'(a_ce), 16'h3);
        chk("resync_first_phase", 16'(a_phase), 16'h3);
        rd_chk(0, "rd_ctrl_resync_clear", 16'hFF7C, 8'h03);
        rd_chk(0, "rd_div0_restored", 16'hFF78, 8'h03);

        // DIV0=1 written on the terminal-count edge 29: old ratio until 33, then period 2.
        tick(); tick(); tick();
        wr(0, 16'hFF78, 8'h01);
        chk("same_edge_tc_29", 16'(a_ce[0]), 16'h1);
        for (int e = 30; e <= 32; e++) begin tick(); chk("same_edge_old_ratio", 16'(a_ce[0]), 16'h0); end
        tick(); chk("same_edge_ce_33", 16'(a_ce[0]), 16'h1);
        tick(); chk("new_ratio_gap_34", 16'(a_ce[0]), 16'h0);
        tick(); chk("new_ratio_ce_35", 16'(a_ce[0]), 16'h1);
        tick(); chk("new_ratio_gap_36", 16'(a_ce[0]), 16'h0);
        tick(); chk("new_ratio_ce_37", 16'(a_ce), 16'h3);

        // Asynchronous reset mid-cycle while CE is high.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ce", 16'(a_ce), 16'h0);
        chk("async_rst_phase", 16'(a_phase), 16'h0);
        chk("async_rst_b_ce", 16'(b_ce), 16'h0);
        #1;
        rst_n = 1'b1;
        tick();
        rd_chk(0, "rd_div0_after_rst", 16'hFF78, 8'h03);
        rd_chk(0, "rd_div1_after_rst", 16'hFF7A, 8'h03);
        rd_chk(0, "rd_ctrl_after_rst", 16'hFF7C, 8'h03);

        // 12-bit instance: load 0xFFF right after a CE, picked up at the next terminal count.
        rd_chk(1, "b_rd_ctrl", 16'hFF7A, 8'h01);
        n = 0;
        while (b_ce !== 1'b1 && n < 8) begin tick(); n++; end
        chk("b_first_ce_found", 16'(b_ce), 16'h1);
        wr(1, 16'hFF78, 8'hFF);
        wr(1, 16'hFF79, 8'hFF);
        rd_chk(1, "b_rd_div_hi", 16'hFF79, 8'h0F);
        rd_chk(1, "b_rd_div_lo", 16'hFF78, 8'hFF);
        tick(); chk("b_old_ratio_gap", 16'(b_ce), 16'h0);
        tick(); chk("b_tc_loads_fff", 16'(b_ce), 16'h1);
        hits = 0;
        for (int i = 0; i < 4095; i++) begin
            tick();
            if (b_ce === 1'b1) hits++;
        end
        chk("b_no_early_ce", 16'(hits), 16'h0);
        tick(); chk("b_period_4096", 16'(b_ce), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
